spi_burst_shifter: RTL and testbench
====================================

# spi_burst_shifter

Parametrised SPI master shift engine for the SD interface. It moves a burst of `count` words of `DATA_W` bits. The word clock rate comes from a programmable divider, and the idle clock polarity is selectable. Transmit words arrive over a valid/ready handshake and received words leave as one-cycle strobes. A CRC16 (x^16+x^12+x^5+1) is computed over either the MOSI or the MISO bit stream. It sits between the register/DMA front end and the card pins, and replaces the fixed 8-bit byte shifter.

## Interface
- `DATA_W`, 8: word width in bits, ≥ 2.
- `CNT_W`, 10: width of the burst word count.
- `DIV_W`, 6: width of the SCLK half-period divider.

- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: begin a burst. Accepted only when idle.
- `read_mode` in 1: 1 means MOSI is forced high and tx words are not consumed. Latched at `start`.
- `count` in CNT_W: number of words in the burst. Latched at `start`.
- `div` in DIV_W: each SCLK phase lasts `div`+1 clk cycles. Latched at `start`.
- `cpol` in 1: SCLK idle level. Latched at `start`.
- `tx_data` in DATA_W: transmit word, MSB sent first.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: the engine takes `tx_data` this cycle.
- `rx_data` out DATA_W: last received word.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is new.
- `crc_reset` in 1: clear the CRC.
- `crc_source` in 1: 0 means the CRC runs over MOSI bits, 1 over MISO bits.
- `crc_out` out 16: CRC register.
- `miso` in 1; `mosi` out 1; `sclk` out 1.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle strobe at burst end.

## Operation

**States**
- IDLE:
  - `start` with `count` ≠ 0 latches `read_mode`, `count`, `div` and `cpol`, then goes to LOAD.
  - `start` with `count` = 0 is ignored.
- LOAD:
  - Write mode: `tx_ready` = 1. When `tx_valid` & `tx_ready`, the shifter takes `tx_data`, the bit counter is cleared, and the state goes to PH_A.
  - Write mode with `tx_valid` low: stay in LOAD. SCLK holds its idle level (underrun stall, no error).
  - Read mode: one cycle, shifter unchanged, then PH_A; `tx_ready` stays 0.
- PH_A: SCLK at its idle level for `div`+1 cycles, then PH_B.
- PH_B: SCLK at the inverted idle level for `div`+1 cycles. On the clk edge that ends PH_B (the SCLK trailing edge):
  - the shifter takes {shifter[DATA_W-2:0], `miso`};
  - the CRC is updated;
  - the bit counter increments.
  - If that was bit DATA_W-1, go to WORD_END; otherwise go to PH_A.
- WORD_END: this cycle only.
  - `rx_valid` = 1; `rx_data` already holds the full received word.
  - The remaining word count is decremented.
  - If words remain, behave as LOAD in this same cycle (handshake allowed, so this cycle is the next word's LOAD cycle).
  - Otherwise assert `done`, set `busy` = 0 and return to IDLE.

**Outputs**
- `mosi` = shifter MSB in write mode; 1 in read mode and in IDLE.
- `sclk` = `cpol` input directly while IDLE; the latched `cpol`, or its inverse in PH_B, while busy.
- CRC bit input = (`crc_source` ? `miso` : shifter MSB) XOR crc[15]. Update: crc ← {crc[14:0], 0}, then XOR 0x1021 if the bit input is 1.
- A CRC bit update has priority over `crc_reset` in the same cycle.
- `crc_source` is sampled live at each bit update.
- `rx_data` is not back-pressured; the consumer must take every `rx_valid`.
- `start` while busy is ignored. `read_mode`, `count`, `div` and `cpol` changes while busy have no effect.

**Reset** (`rst` low at a clk edge, including mid-burst): state IDLE, `busy` 0, `done` 0, `tx_ready` 0, `rx_valid` 0, `rx_data` 0, `crc_out` 0, `mosi` 1, `sclk` = `cpol`. Any partial word is discarded with no `rx_valid`.

## Timing
- `start` in cycle 0 gives `busy` = 1 from cycle 1; cycle 1 is LOAD.
- With `tx_valid` held high, each word takes exactly 1 + 2·DATA_W·(`div`+1) cycles.
- `busy` is high for N·(1 + 2·DATA_W·(`div`+1)) cycles. In the cycle after the last trailing edge, `rx_valid` = `done` = 1 and `busy` = 0.
- MOSI changes only at the PH_B end edge (or at LOAD); it is stable for the full SCLK high phase (`cpol`=0).
- Each stalled LOAD cycle adds one cycle. SCLK does not toggle during a stall.
- `div` = 0 gives SCLK = clk/2, the maximum rate.

## Test plan
- **Single word, write:** `DATA_W`=8, `div`=0, `count`=1, `cpol`=0, `tx_data`=0xA5 valid, `miso`=1.
  - MOSI sequence 1,0,1,0,0,1,0,1; 8 SCLK pulses, each 1 cycle high.
  - `rx_data`=0xFF with `rx_valid` and `done` in cycle 18; `busy` high in cycles 1–17.
- **CRC over MOSI:** `crc_reset`, then a 9-word burst of ASCII "123456789", `crc_source`=0 → `crc_out`=0x31C3.
- **Read mode:** `count`=2, `div`=2, `miso` pattern 0x3C then 0xC3.
  - `mosi` constantly 1, `tx_ready` never asserted.
  - `rx_valid` at cycles 50 and 99 with `rx_data` 0x3C then 0xC3; `done` at 99.
- **Underrun stall:** `count`=2, `tx_valid` dropped for 5 cycles before word 2.
  - SCLK idle through the stall, `busy` stays 1, total burst length extended by 5 cycles.
- **Polarity and divider:** `cpol`=1, `div`=3 → SCLK idles high, low phase 4 cycles, high phase 4 cycles; `cpol` change mid-burst has no effect.
- **Reset mid-burst:** `rst` low during bit 4 of word 1 → next cycle all outputs at reset values and no `rx_valid`. A following `start` runs a full, correct burst.

Source files
------------

// File: rtl/spi_burst_shifter_if.sv
// Bus bundle for the SPI burst shift engine: burst control, tx/rx word
// streams, CRC control/result and the card-side pins.
interface spi_burst_shifter_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 10,
    parameter int DIV_W  = 6
);
    logic              start;
    logic              read_mode;
    logic [CNT_W-1:0]  count;
    logic [DIV_W-1:0]  div;
    logic              cpol;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              crc_reset;
    logic              crc_source;
    logic [15:0]       crc_out;
    logic              miso;
    logic              mosi;
    logic              sclk;
    logic              busy;
    logic              done;

    // Front end / bench side
    modport master (
        output start, read_mode, count, div, cpol, tx_data, tx_valid,
               crc_reset, crc_source, miso,
        input  tx_ready, rx_data, rx_valid, crc_out, mosi, sclk, busy, done
    );

    // Shift engine side
    modport slave (
        input  start, read_mode, count, div, cpol, tx_data, tx_valid,
               crc_reset, crc_source, miso,
        output tx_ready, rx_data, rx_valid, crc_out, mosi, sclk, busy, done
    );
endinterface

// File: rtl/spi_burst_shifter.sv
// SPI master burst shift engine: moves `count` words of DATA_W bits MSB
// first, SCLK half-period of div+1 clocks, selectable idle polarity, and a
// CRC16 (0x1021) over either the MOSI or the MISO bit stream.
module spi_burst_shifter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 10,
    parameter int DIV_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    spi_burst_shifter_if.slave  bus
);
    localparam int          BIT_W    = $clog2(DATA_W);
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PH_A, S_PH_B, S_WORD_END
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_read_mode, r_cpol;
    logic [CNT_W-1:0]  r_words_left;
    logic [DIV_W-1:0]  r_div, r_div_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift, r_rx_data;
    logic [15:0]       r_crc;

    logic w_start, w_load_slot, w_advance, w_last_word, w_last_bit;
    logic w_phase_end, w_bit_edge, w_crc_in;
    logic w_tx_ready, w_busy, w_done, w_rx_valid, w_mosi, w_sclk;
    logic [15:0] w_crc_next;

    assign w_phase_end = (r_div_cnt == r_div);
    assign w_last_word = (r_words_left == CNT_W'(1));
    assign w_last_bit  = (r_bit_cnt == BIT_W'(DATA_W - 1));
    assign w_bit_edge  = (r_state == S_PH_B) && w_phase_end;
    assign w_start     = (r_state == S_IDLE) && bus.start && (bus.count != '0);
    // WORD_END doubles as the next word's load cycle when words remain
    assign w_load_slot = (r_state == S_LOAD) ||
                         ((r_state == S_WORD_END) && !w_last_word);
    assign w_advance   = w_load_slot && (r_read_mode || bus.tx_valid);
    assign w_crc_in    = (bus.crc_source ? bus.miso : r_shift[DATA_W-1]) ^ r_crc[15];

    // CRC next value: shift left, fold in the polynomial when the feedback bit is set
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_crc
            if (gi == 0) begin : g_lsb
                assign w_crc_next[gi] = CRC_POLY[gi] & w_crc_in;
            end else begin : g_upper
                assign w_crc_next[gi] = r_crc[gi-1] ^ (CRC_POLY[gi] & w_crc_in);
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    // Next-state and output decode
    always_comb begin
        w_state_next = r_state;
        w_tx_ready   = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_rx_valid   = 1'b0;
        w_mosi       = r_read_mode ? 1'b1 : r_shift[DATA_W-1];
        w_sclk       = r_cpol;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                w_mosi = 1'b1;
                w_sclk = bus.cpol;
                if (w_start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_tx_ready = !r_read_mode;
                if (w_advance) w_state_next = S_PH_A;
            end
            S_PH_A: begin
                if (w_phase_end) w_state_next = S_PH_B;
            end
            S_PH_B: begin
                w_sclk = ~r_cpol;
                if (w_phase_end) w_state_next = w_last_bit ? S_WORD_END : S_PH_A;
            end
            S_WORD_END: begin
                w_rx_valid = 1'b1;
                if (w_last_word) begin
                    w_busy       = 1'b0;
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_tx_ready   = !r_read_mode;
                    w_state_next = w_advance ? S_PH_A : S_LOAD;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Burst configuration latched at start; remaining word count
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_read_mode  <= 1'b0;
            r_cpol       <= 1'b0;
            r_div        <= '0;
            r_words_left <= '0;
        end else if (w_start) begin
            r_read_mode  <= bus.read_mode;
            r_cpol       <= bus.cpol;
            r_div        <= bus.div;
            r_words_left <= bus.count;
        end else if (r_state == S_WORD_END) begin
            r_words_left <= r_words_left - CNT_W'(1);
        end
    end

    // SCLK phase timer and bit counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (w_advance) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else if ((r_state == S_PH_A) || (r_state == S_PH_B)) begin
            r_div_cnt <= w_phase_end ? '0 : r_div_cnt + DIV_W'(1);
            if (w_bit_edge) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
    end

    // Shift register: load tx word, shift MISO in on each SCLK trailing edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift   <= '0;
            r_rx_data <= '0;
        end else if (w_advance && !r_read_mode) begin
            r_shift <= bus.tx_data;
        end else if (w_bit_edge) begin
            r_shift <= {r_shift[DATA_W-2:0], bus.miso};
            if (w_last_bit) r_rx_data <= {r_shift[DATA_W-2:0], bus.miso};
        end
    end

    // CRC register; a bit update wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst)               r_crc <= '0;
        else if (w_bit_edge)    r_crc <= w_crc_next;
        else if (bus.crc_reset) r_crc <= '0;
    end

    assign bus.tx_ready = w_tx_ready;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = w_rx_valid;
    assign bus.crc_out  = r_crc;
    assign bus.mosi     = w_mosi;
    assign bus.sclk     = w_sclk;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
endmodule

// File: tb/tb_spi_burst_shifter.sv
// Bench for spi_burst_shifter: each burst is turned into a cycle timeline
// (load/stall windows, bit windows, word ends) by plain arithmetic, and every
// cycle of the DUT is compared against that timeline.
module tb_spi_burst_shifter;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 10;
    localparam int DIV_W  = 6;
    localparam int MAXT   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_burst_shifter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

    spi_burst_shifter #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]  m_tx [16];
    logic [7:0]  m_rx [16];
    int          m_stall [16];
    logic [15:0] m_crc = 16'h0;
    logic [7:0]  m_rx_last = 8'h0;
    logic        cur_cpol = 1'b0;
    int          burst_no = 0;

    // Per-cycle timeline of the current burst
    int   a_bit  [MAXT];
    int   a_load [MAXT];
    int   a_end  [MAXT];
    bit   a_phb  [MAXT];
    bit   a_hs   [MAXT];
    logic [15:0] e_crc [16];

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic drive_benign();
        bus.start      = 1'b0;
        bus.read_mode  = 1'b0;
        bus.count      = '0;
        bus.div        = '0;
        bus.cpol       = cur_cpol;
        bus.tx_data    = 8'($urandom());
        bus.tx_valid   = 1'($urandom_range(0, 1));
        bus.crc_reset  = 1'b0;
        bus.crc_source = 1'b0;
        bus.miso       = 1'($urandom_range(0, 1));
    endtask

    task automatic check_quiet(input logic [15:0] crc_exp);
        check_eq("idle_busy",     32'(bus.busy),     32'd0);
        check_eq("idle_done",     32'(bus.done),     32'd0);
        check_eq("idle_tx_ready", 32'(bus.tx_ready), 32'd0);
        check_eq("idle_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_eq("idle_mosi",     32'(bus.mosi),     32'd1);
        check_eq("idle_sclk",     32'(bus.sclk),     32'(cur_cpol));
        check_eq("idle_rx_data",  32'(bus.rx_data),  32'(m_rx_last));
        check_eq("idle_crc",      32'(bus.crc_out),  32'(crc_exp));
    endtask

    // One idle cycle (entered just after a rising edge)
    task automatic idle_cycle();
        drive_benign();
        @(negedge clk);
        check_quiet(m_crc);
        @(posedge clk); #1;
    endtask

    task automatic run_burst(input int n, input int d, input bit cp, input bit rd,
                             input bit src, input bit hold, input int abort_at,
                             output int done_at);
        int p, t, tdone, k, b, lo, hi;
        logic [15:0] c;
        logic bv;
        bit aborted;
        p = d + 1;
        done_at = -1;
        aborted = 0;
        for (int i = 0; i < MAXT; i++) begin
            a_bit[i] = -1; a_load[i] = -1; a_end[i] = -1; a_phb[i] = 0; a_hs[i] = 0;
        end
        // Timeline: load window (with stall), 8 bit windows of 2p cycles, word end
        t = 1;
        for (int w = 0; w < n; w++) begin
            lo = t;
            hi = t + (rd ? 0 : m_stall[w]);
            for (int i = lo; i <= hi; i++) a_load[i] = w;
            a_hs[hi] = 1;
            for (int bb = 0; bb < 8; bb++) begin
                for (int i = hi + 1 + 2*p*bb; i <= hi + 2*p*(bb+1); i++) begin
                    a_bit[i] = w*8 + bb;
                    if (i > hi + p + 2*p*bb) a_phb[i] = 1;
                end
            end
            t = hi + 16*p + 1;
            a_end[t] = w;
        end
        tdone = t;
        // Expected CRC after each word
        c = m_crc;
        for (int w = 0; w < n; w++) begin
            for (int bb = 0; bb < 8; bb++) begin
                bv = src ? m_rx[w][7-bb] : m_tx[w][7-bb];
                c = crc_step(hold ? 16'h0 : c, bv);
            end
            e_crc[w] = c;
        end

        for (int cyc = 0; cyc <= tdone + 1; cyc++) begin
            rst = (abort_at > 0 && cyc == abort_at) ? 1'b0 : 1'b1;
            if (cyc == 0) begin
                bus.start = 1'b1; bus.count = CNT_W'(n); bus.read_mode = rd;
                bus.div = DIV_W'(d); cur_cpol = cp;
            end else begin
                bus.start = (cyc <= tdone && !(abort_at > 0 && cyc > abort_at)) ?
                            1'($urandom_range(0, 1)) : 1'b0;
                bus.count = CNT_W'($urandom());
                bus.read_mode = 1'($urandom_range(0, 1));
                bus.div = DIV_W'($urandom());
                cur_cpol = 1'($urandom_range(0, 1));
            end
            bus.cpol = cur_cpol;
            bus.crc_reset = (hold && cyc <= tdone) ? 1'b1 : 1'b0;
            bus.crc_source = src;
            if (a_load[cyc] >= 0) begin
                bus.tx_data  = m_tx[a_load[cyc]];
                bus.tx_valid = a_hs[cyc];
            end else begin
                bus.tx_data  = 8'($urandom());
                bus.tx_valid = 1'($urandom_range(0, 1));
            end
            if (a_bit[cyc] >= 0) begin
                k = a_bit[cyc] / 8; b = a_bit[cyc] % 8;
                bus.miso = m_rx[k][7-b];
            end else begin
                bus.miso = 1'($urandom_range(0, 1));
            end

            @(negedge clk);
            if (abort_at > 0 && cyc == abort_at + 1) begin
                m_crc = 16'h0; m_rx_last = 8'h0;
                check_eq("rst_busy",     32'(bus.busy),     32'd0);
                check_eq("rst_done",     32'(bus.done),     32'd0);
                check_eq("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
                check_eq("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
                check_eq("rst_rx_data",  32'(bus.rx_data),  32'd0);
                check_eq("rst_crc",      32'(bus.crc_out),  32'd0);
                check_eq("rst_mosi",     32'(bus.mosi),     32'd1);
                check_eq("rst_sclk",     32'(bus.sclk),     32'(cur_cpol));
                aborted = 1;
            end else begin
                check_eq("busy", 32'(bus.busy), 32'(cyc >= 1 && cyc < tdone));
                check_eq("sclk", 32'(bus.sclk),
                         32'((cyc >= 1 && cyc <= tdone) ? (cp ^ a_phb[cyc]) : cur_cpol));
                if (rd || cyc == 0 || cyc > tdone) begin
                    check_eq("mosi", 32'(bus.mosi), 32'd1);
                end else if (a_bit[cyc] >= 0) begin
                    k = a_bit[cyc] / 8; b = a_bit[cyc] % 8;
                    check_eq("mosi", 32'(bus.mosi), 32'(m_tx[k][7-b]));
                end
                check_eq("tx_ready", 32'(bus.tx_ready), 32'(!rd && a_load[cyc] >= 0));
                check_eq("rx_valid", 32'(bus.rx_valid), 32'(a_end[cyc] >= 0));
                check_eq("done",     32'(bus.done),     32'(cyc == tdone));
                if (a_end[cyc] >= 0) begin
                    m_rx_last = m_rx[a_end[cyc]];
                    check_eq("crc_word", 32'(bus.crc_out), 32'(e_crc[a_end[cyc]]));
                end
                if (cyc == 0) check_eq("crc_start", 32'(bus.crc_out), 32'(m_crc));
                check_eq("rx_data", 32'(bus.rx_data), 32'(m_rx_last));
                if (bus.done === 1'b1 && done_at < 0) done_at = cyc;
            end
            @(posedge clk); #1;
            if (aborted) break;
        end
        rst = 1'b1;
        if (!aborted) m_crc = hold ? 16'h0 : e_crc[n-1];
        $display("burst %0d: n=%0d div=%0d cpol=%0d read=%0d src=%0d hold=%0d abort=%0d done_at=%0d crc=%04h",
                 burst_no, n, d, cp, rd, src, hold, abort_at, done_at, m_crc);
        burst_no++;
    endtask

    task automatic fill_words(input int n, input bit rd);
        for (int w = 0; w < n; w++) begin
            m_tx[w] = 8'($urandom());
            m_rx[w] = 8'($urandom());
            m_stall[w] = rd ? 0 : $urandom_range(0, 3);
        end
    endtask

    int done_at;
    string msg;

    initial begin
        cur_cpol = 1'b1;
        drive_benign();
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_quiet(16'h0);
        cur_cpol = 1'b0;
        bus.cpol = 1'b0;
        #1;
        check_eq("rst_sclk_live", 32'(bus.sclk), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycle();

        // Single word write, div 0
        m_tx[0] = 8'hA5; m_rx[0] = 8'hFF; m_stall[0] = 0;
        run_burst(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, done_at);
        check_eq("single_done_cycle", 32'(done_at), 32'd18);
        check_eq("single_rx_data", 32'(bus.rx_data), 32'hFF);

        // CRC over MOSI of "123456789"
        drive_benign();
        bus.crc_reset = 1'b1;
        @(posedge clk); #1;
        m_crc = 16'h0;
        idle_cycle();
        msg = "123456789";
        for (int w = 0; w < 9; w++) begin
            m_tx[w] = msg[w];
            m_rx[w] = 8'($urandom());
            m_stall[w] = 0;
        end
        run_burst(9, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, done_at);
        check_eq("crc_check_value", 32'(bus.crc_out), 32'h31C3);

        // Read mode, two words, div 2
        m_rx[0] = 8'h3C; m_rx[1] = 8'hC3; m_tx[0] = 8'h00; m_tx[1] = 8'h00;
        run_burst(2, 2, 1'b0, 1'b1, 1'b1, 1'b0, 0, done_at);
        check_eq("read_done_cycle", 32'(done_at), 32'd99);

        // Underrun stall of 5 cycles before word 2
        fill_words(2, 1'b0);
        m_stall[0] = 0; m_stall[1] = 5;
        run_burst(2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, done_at);
        check_eq("stall_done_cycle", 32'(done_at), 32'd40);

        // Idle-high clock, div 3, cpol input toggled during the burst
        fill_words(2, 1'b0);
        m_stall[0] = 0; m_stall[1] = 0;
        run_burst(2, 3, 1'b1, 1'b0, 1'b1, 1'b0, 0, done_at);
        check_eq("cpol1_done_cycle", 32'(done_at), 32'd131);

        // crc_reset held through a burst: bit updates still take priority
        fill_words(3, 1'b0);
        run_burst(3, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0, done_at);

        // start with count 0 is ignored
        drive_benign();
        bus.start = 1'b1;
        bus.count = '0;
        @(posedge clk); #1;
        idle_cycle();
        idle_cycle();

        // Reset during bit 4 of word 1, then a clean burst
        fill_words(2, 1'b0);
        m_stall[0] = 0;
        run_burst(2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 19, done_at);
        for (int i = 0; i < 4; i++) idle_cycle();
        fill_words(2, 1'b0);
        run_burst(2, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0, done_at);

        // Randomized bursts
        for (int r = 0; r < 25; r++) begin
            int n, d;
            bit rd, src, hold, cp;
            n    = $urandom_range(1, 4);
            d    = $urandom_range(0, 3);
            rd   = 1'($urandom_range(0, 1));
            src  = rd ? 1'b1 : 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 5) == 0);
            cp   = 1'($urandom_range(0, 1));
            fill_words(n, rd);
            run_burst(n, d, cp, rd, src, hold, 0, done_at);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
